// File: rtl/imgbuf_pkg.sv
// Shared types and default sizing for the image frame buffer.
package imgbuf_pkg;

   localparam int IMGBUF_DATA_W = 8;
   localparam int IMGBUF_DEPTH  = 152100;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_FULL,
      ST_DUMP
   } state_t;

endpackage

// File: rtl/imgbuf_ram.sv
// Simple dual-port pixel store: one write port, one registered read port.
module imgbuf_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int IDX_W  = 2
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [IDX_W-1:0]  rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // No reset on the array or output so this maps onto block RAM; a same-address
   // read and write in one cycle returns the previous contents.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/image_frame_buffer.sv
// Frame buffer: fill a frame by random-access writes, read it back, stream it out.
// Optional IMGBUF_BOUNDS_CHECK_EN drops out-of-range accesses and raises err_oob.
module image_frame_buffer
   import imgbuf_pkg::*;
#(
   parameter int DATA_W = IMGBUF_DATA_W,
   parameter int DEPTH  = IMGBUF_DEPTH,
   parameter int ADDR_W = 32
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   output logic                       wr_ready,
   input  logic                       rd_en,
   input  logic [ADDR_W-1:0]          rd_addr,
   output logic [DATA_W-1:0]          rd_data,
   output logic                       rd_valid,
   input  logic                       dump_start,
   output logic                       dump_valid,
   output logic [DATA_W-1:0]          dump_data,
   output logic                       dump_last,
   input  logic                       dump_ready,
   output logic                       frame_done,
   output logic [$clog2(DEPTH+1)-1:0] pix_count,
   output logic                       err_oob
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  pix_count_q, pix_count_d;
   logic [CNT_W-1:0]  dump_idx_q, dump_idx_d;
   logic              rd_valid_q, rd_valid_d;
   logic              rd_oob_q, rd_oob_d;
   logic              err_oob_q, err_oob_d;
   logic              fetch_valid_q, fetch_valid_d;
   logic              fetch_last_q, fetch_last_d;
   logic              dump_valid_q, dump_valid_d;
   logic              dump_last_q, dump_last_d;
   logic [DATA_W-1:0] dump_data_q, dump_data_d;

   logic              wr_in_range, rd_in_range;
   logic              wr_accept, wr_store, rd_take;
   logic              out_adv, fetch_adv, fetch_issue, last_handshake;
   logic              ram_rd_en;
   logic [IDX_W-1:0]  ram_rd_addr;
   logic [DATA_W-1:0] ram_dout;

`ifdef IMGBUF_BOUNDS_CHECK_EN
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
`else
   logic unused_addr_hi;
   assign unused_addr_hi = ^{wr_addr[ADDR_W-1:IDX_W], rd_addr[ADDR_W-1:IDX_W]};
`endif

   assign wr_ready = (state_q == ST_IDLE) || (state_q == ST_FILL);

   // The stream is a two-stage pipe: the RAM output register holds the fetched
   // pixel, dump_data_q holds the offered one; each stage only advances when the
   // stage after it is empty or draining, so a stall freezes both.
   always_comb begin
      wr_in_range = 1'b1;
      rd_in_range = 1'b1;
`ifdef IMGBUF_BOUNDS_CHECK_EN
      wr_in_range = (wr_addr < DEPTH_A);
      rd_in_range = (rd_addr < DEPTH_A);
`endif
      wr_accept      = wr_en && wr_ready;
      wr_store       = wr_accept && wr_in_range;
      rd_take        = rd_en && (state_q != ST_DUMP);
      out_adv        = !dump_valid_q || dump_ready;
      fetch_adv      = !fetch_valid_q || out_adv;
      fetch_issue    = (state_q == ST_DUMP) && fetch_adv && (dump_idx_q < DEPTH_C);
      last_handshake = dump_valid_q && dump_ready && dump_last_q;

      state_d       = state_q;
      pix_count_d   = pix_count_q;
      dump_idx_d    = dump_idx_q;
      rd_valid_d    = rd_take;
      rd_oob_d      = rd_take && !rd_in_range;
      fetch_valid_d = fetch_valid_q;
      fetch_last_d  = fetch_last_q;
      dump_valid_d  = dump_valid_q;
      dump_last_d   = dump_last_q;
      dump_data_d   = dump_data_q;
`ifdef IMGBUF_BOUNDS_CHECK_EN
      err_oob_d = err_oob_q || (wr_accept && !wr_in_range) || (rd_take && !rd_in_range);
`else
      err_oob_d = 1'b0;
`endif

      if (wr_store && (pix_count_q != DEPTH_C)) begin
         pix_count_d = pix_count_q + CNT_W'(1);
      end

      if (fetch_adv) begin
         fetch_valid_d = fetch_issue;
         fetch_last_d  = fetch_issue && (dump_idx_q == DEPTH_C - CNT_W'(1));
      end
      if (fetch_issue) begin
         dump_idx_d = dump_idx_q + CNT_W'(1);
      end
      if (out_adv) begin
         dump_valid_d = fetch_valid_q;
         dump_last_d  = fetch_valid_q && fetch_last_q;
         dump_data_d  = fetch_valid_q ? ram_dout : '0;
      end

      case (state_q)
         ST_IDLE: if (wr_store) state_d = ST_FILL;
         ST_FILL: if (pix_count_q == DEPTH_C) state_d = ST_FULL;
         ST_FULL: begin
            if (dump_start) begin
               state_d    = ST_DUMP;
               dump_idx_d = '0;
            end
         end
         ST_DUMP: begin
            if (last_handshake) begin
               state_d     = ST_IDLE;
               pix_count_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      ram_rd_en   = fetch_issue || (rd_take && rd_in_range);
      ram_rd_addr = (state_q == ST_DUMP) ? dump_idx_q[IDX_W-1:0] : rd_addr[IDX_W-1:0];
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q       <= ST_IDLE;
         pix_count_q   <= '0;
         dump_idx_q    <= '0;
         rd_valid_q    <= 1'b0;
         rd_oob_q      <= 1'b0;
         err_oob_q     <= 1'b0;
         fetch_valid_q <= 1'b0;
         fetch_last_q  <= 1'b0;
         dump_valid_q  <= 1'b0;
         dump_last_q   <= 1'b0;
         dump_data_q   <= '0;
      end else begin
         state_q       <= state_d;
         pix_count_q   <= pix_count_d;
         dump_idx_q    <= dump_idx_d;
         rd_valid_q    <= rd_valid_d;
         rd_oob_q      <= rd_oob_d;
         err_oob_q     <= err_oob_d;
         fetch_valid_q <= fetch_valid_d;
         fetch_last_q  <= fetch_last_d;
         dump_valid_q  <= dump_valid_d;
         dump_last_q   <= dump_last_d;
         dump_data_q   <= dump_data_d;
      end
   end

   imgbuf_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_ram (
      .clk     (CLK),
      .wr_en   (wr_store),
      .wr_addr (wr_addr[IDX_W-1:0]),
      .wr_data (wr_data),
      .rd_en   (ram_rd_en),
      .rd_addr (ram_rd_addr),
      .rd_data (ram_dout)
   );

   assign rd_valid   = rd_valid_q;
   assign rd_data    = (rd_valid_q && !rd_oob_q) ? ram_dout : '0;
   assign dump_valid = dump_valid_q;
   assign dump_data  = dump_data_q;
   assign dump_last  = dump_last_q;
   assign frame_done = (state_q == ST_FULL);
   assign pix_count  = pix_count_q;
   assign err_oob    = err_oob_q;

endmodule
